alu_op_controller: RTL and testbench
====================================

Name: alu_op_controller

Overview:
- Sequencing front end for the 32-bit ALU; the producer side of the ALU's 3-bit result-select interface.
- Accepts operation requests (opcode, A, B) over a valid/ready handshake and drives the ALU operand buses and the 3-bit select.
- Starts and waits on the multi-cycle modulo unit, captures the selected result and returns it over a valid/ready response channel.
- Sits between the instruction/test driver and the ALU datapath.

Parameters:
- WIDTH, 32, operand/result width.
- MOD_TIMEOUT, 64, maximum cycles spent waiting for mod_done before aborting with an error; must be >= 2.
- TO_W, $clog2(MOD_TIMEOUT+1), timeout counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  opcode: 000 and, 001 or, 010 xor, 011 nor, 100 lessthan, 101 add, 110 sub, 111 mod.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- alu_a  out  WIDTH  registered operand A to the ALU.
- alu_b  out  WIDTH  registered operand B to the ALU.
- alu_sel  out  3  registered result select to the ALU's 8:1 result mux; equals the latched opcode.
- alu_result  in  WIDTH  ALU muxed result.
- alu_cout  in  1  ALU adder carry-out, valid for add/sub.
- mod_start  out  1  one-cycle start pulse to the modulo unit.
- mod_done  in  1  modulo unit result ready; alu_result is valid in the same cycle.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  captured result.
- rsp_cout  out  1  captured carry; 0 for all ops except add/sub.
- rsp_err  out  1  1 = mod by zero or mod timeout.

Behaviour:
- Reset (async on rst_n low, released synchronously to clk):
  - State IDLE.
  - req_ready=1; alu_a=0, alu_b=0, alu_sel=000, mod_start=0.
  - rsp_valid=0, rsp_data=0, rsp_cout=0, rsp_err=0; timeout counter=0.
- Reset mid-operation discards any in-flight request and response without completing it.
- Handshake:
  - A transfer occurs on a rising edge when valid&&ready on that channel.
  - req_ready=1 only in IDLE.
  - rsp_valid=1 only in HOLD.
  - rsp_data, rsp_cout and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- States and transitions:
  - IDLE: on request accept, latch req_op into alu_sel, req_a into alu_a, req_b into alu_b.
    - op!=111: go to EXEC.
    - op==111 and req_b==0: set rsp_data=0, rsp_cout=0, rsp_err=1; go to HOLD. No mod_start is issued.
    - op==111 and req_b!=0: mod_start=1 for the next cycle only; clear the timeout counter; go to MWAIT.
  - EXEC (exactly one cycle): capture rsp_data=alu_result; rsp_cout=alu_cout if op is 101/110, else 0; rsp_err=0; go to HOLD.
  - MWAIT: mod_start=0 after its first cycle; the counter increments each cycle.
    - If mod_done=1: capture rsp_data=alu_result, rsp_err=0; go to HOLD.
    - Else if the counter reaches MOD_TIMEOUT: rsp_data=0, rsp_err=1; go to HOLD.
    - If mod_done and timeout occur in the same cycle, mod_done wins.
  - HOLD: rsp_valid=1. On rsp_ready=1, go to IDLE; req_ready=1 in the following cycle.
- Latency:
  - Non-mod op accepted at edge E: rsp_valid=1 after edge E+2.
  - Mod-by-zero: rsp_valid=1 after edge E+1.
  - Mod: rsp_valid=1 one edge after the edge at which mod_done is sampled high.
- Throughput: at most one request per 3 cycles (no overlap, by design).
- alu_a, alu_b and alu_sel hold their last values in all states after capture; they do not return to 0.
- mod_done sampled outside MWAIT is ignored.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_AND..OP_MOD (3'b000..3'b111), common with the ALU result mux select encoding.
  - state encoding localparams IDLE, EXEC, MWAIT, HOLD.
- No sub-module: the timeout counter and the FSM live in one module.

Test Plan:
- Reset with rst_n=0 mid-MWAIT, then release -> all outputs at reset values, req_ready=1, no rsp_valid pulse.
- op=101, a=0xFFFFFFFF, b=1, ALU model returns 0 with cout=1, rsp_ready=1 -> alu_sel=101; rsp_valid after edge E+2 with rsp_data=0, rsp_cout=1, rsp_err=0; req_ready=1 two cycles later.
- op=000, a=0xF0F0F0F0, b=0x0FF00FF0, rsp_ready held 0 for 5 cycles -> rsp_data=0x00F000F0 held stable for 5 cycles, req_ready=0 throughout, then a single transfer.
- op=111, a=17, b=5, model raises mod_done with result 2 after 4 cycles -> exactly one mod_start pulse, rsp_data=2, rsp_err=0.
- op=111, b=0 -> no mod_start, rsp_valid after edge E+1, rsp_data=0, rsp_err=1.
- op=111, b=3, mod_done never asserted -> rsp_err=1, rsp_data=0 after exactly MOD_TIMEOUT (64) MWAIT cycles.
- Variant of the timeout case with mod_done asserted on cycle 64 -> success response, rsp_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencing front end: opcode encoding
// (identical to the ALU result-mux select) and controller state encoding.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    MWAIT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Only the adder ops produce a meaningful carry-out.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_op_controller_if.sv
// Bundle of request, response, ALU operand/select and modulo-unit signals.
// master = the controller; slave = driver, consumer and ALU datapath side.
interface alu_op_controller_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;

  logic             mod_start;
  logic             mod_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_cout;
  logic             rsp_err;

  modport master (
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_cout,
    output mod_start,
    input  mod_done,
    output rsp_valid, rsp_data, rsp_cout, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_cout,
    input  mod_start,
    output mod_done,
    input  rsp_valid, rsp_data, rsp_cout, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/alu_op_controller.sv
// Sequencing front end for the ALU: accepts one operation at a time, drives
// registered operands/select, runs the multi-cycle modulo unit with a
// timeout, and returns the captured result over a valid/ready response.
// MOD_TIMEOUT must be at least 2.
module alu_op_controller
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MOD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_op_controller_if.master  bus
);

  localparam int TO_W = $clog2(MOD_TIMEOUT + 1);

  state_t           state;
  state_t           state_next;
  logic [TO_W-1:0]  to_cnt;
  logic [TO_W-1:0]  to_cnt_inc;
  logic             timeout_hit;
  logic             req_fire;
  logic             mod_by_zero;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             mod_start_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_cout_q;
  logic             rsp_err_q;

  assign req_fire    = bus.req_valid && (state == IDLE);
  assign mod_by_zero = (bus.req_b == '0);
  assign to_cnt_inc  = to_cnt + TO_W'(1);
  assign timeout_hit = (to_cnt_inc == TO_W'(MOD_TIMEOUT));

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == HOLD);
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.mod_start = mod_start_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_err   = rsp_err_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a completing mod_done takes priority over a timeout.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (req_fire) begin
          if (bus.req_op != OP_MOD) state_next = EXEC;
          else if (mod_by_zero)     state_next = HOLD;
          else                      state_next = MWAIT;
        end
      end
      EXEC:  state_next = HOLD;
      MWAIT: if (bus.mod_done || timeout_hit) state_next = HOLD;
      HOLD:  if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand/select latching, modulo start pulse, timeout counter and
  // response capture. Response registers only change outside HOLD, so they
  // stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= OP_AND;
      mod_start_q <= 1'b0;
      to_cnt      <= '0;
      rsp_data_q  <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      mod_start_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            alu_a_q   <= bus.req_a;
            alu_b_q   <= bus.req_b;
            alu_sel_q <= bus.req_op;
            if (bus.req_op == OP_MOD) begin
              if (mod_by_zero) begin
                rsp_data_q <= '0;
                rsp_cout_q <= 1'b0;
                rsp_err_q  <= 1'b1;
              end else begin
                mod_start_q <= 1'b1;
                to_cnt      <= '0;
              end
            end
          end
        end
        EXEC: begin
          rsp_data_q <= bus.alu_result;
          rsp_cout_q <= op_has_carry(alu_sel_q) ? bus.alu_cout : 1'b0;
          rsp_err_q  <= 1'b0;
        end
        MWAIT: begin
          to_cnt <= to_cnt_inc;
          if (bus.mod_done) begin
            rsp_data_q <= bus.alu_result;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= '0;
            rsp_cout_q <= 1'b0;
            rsp_err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_controller.sv
// Bench for alu_op_controller: directed requests, a behavioural ALU and
// modulo-done driver, and a scoreboard monitor that checks every response
// transfer against expected values queued when each request is issued.
module tb_alu_op_controller;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_controller_if #(.WIDTH(W)) bus ();

  alu_op_controller #(.WIDTH(W), .MOD_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;
  int n_mod_start = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural ALU: carry-out is always driven from the adder so the
  // controller must mask it for non-add/sub ops.
  logic [W:0] sum_add;
  logic [W:0] sum_sub;
  assign sum_add = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
  assign sum_sub = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;

  always_comb begin
    bus.alu_result = '0;
    bus.alu_cout   = sum_add[W];
    case (bus.alu_sel)
      OP_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      OP_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      OP_XOR: bus.alu_result = bus.alu_a ^ bus.alu_b;
      OP_NOR: bus.alu_result = ~(bus.alu_a | bus.alu_b);
      OP_LT:  bus.alu_result = {{(W-1){1'b0}}, (bus.alu_a < bus.alu_b)};
      OP_ADD: bus.alu_result = sum_add[W-1:0];
      OP_SUB: begin
        bus.alu_result = sum_sub[W-1:0];
        bus.alu_cout   = sum_sub[W];
      end
      OP_MOD: bus.alu_result = (bus.alu_b != '0) ? (bus.alu_a % bus.alu_b) : '0;
      default: bus.alu_result = '0;
    endcase
  end

  // Scoreboard.
  typedef struct {
    logic [W-1:0] data;
    logic         cout;
    logic         err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  rsp_t mon_last;
  logic mon_stalled = 1'b0;

  task automatic expect_rsp(input logic [W-1:0] d, input logic c, input logic e);
    rsp_t r;
    r.data = d;
    r.cout = c;
    r.err  = e;
    exp_q.push_back(r);
  endtask

  // Monitor: on each falling edge, a valid&&ready pair means a transfer on
  // the next rising edge; a stalled response must not change.
  always @(negedge clk) begin
    if (rst_n && bus.rsp_valid) begin
      if (mon_stalled) begin
        check("rsp_data_stable", bus.rsp_data, mon_last.data);
        check("rsp_cout_stable", bus.rsp_cout, mon_last.cout);
        check("rsp_err_stable",  bus.rsp_err,  mon_last.err);
      end
      if (bus.rsp_ready) begin
        n_xfer++;
        mon_stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got data 0x%0h err %0b with nothing expected", bus.rsp_data, bus.rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_data", bus.rsp_data, mon_e.data);
          check("rsp_cout", bus.rsp_cout, mon_e.cout);
          check("rsp_err",  bus.rsp_err,  mon_e.err);
        end
      end else begin
        mon_stalled   = 1'b1;
        mon_last.data = bus.rsp_data;
        mon_last.cout = bus.rsp_cout;
        mon_last.err  = bus.rsp_err;
      end
    end else begin
      mon_stalled = 1'b0;
    end
  end

  always @(negedge clk) if (rst_n && bus.mod_start) n_mod_start++;

  task automatic check_reset_values(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_alu_a"},     bus.alu_a,     0);
    check({tag, "_alu_b"},     bus.alu_b,     0);
    check({tag, "_alu_sel"},   bus.alu_sel,   0);
    check({tag, "_mod_start"}, bus.mod_start, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_data"},  bus.rsp_data,  0);
    check({tag, "_rsp_cout"},  bus.rsp_cout,  0);
    check({tag, "_rsp_err"},   bus.rsp_err,   0);
  endtask

  // Present a request once req_ready is seen; e = edge count of acceptance.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    bit seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_ready_timeout: got req_ready 0 expected 1 within 100 cycles");
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    @(posedge clk);
    #1;
    e = cyc;
    bus.req_valid = 1'b0;
  endtask

  // Edge at which rsp_valid is first sampled high, or -1 if it never is.
  task automatic wait_rsp(output int edge_at);
    edge_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        edge_at = cyc + 1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] data;
    logic         cout;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    int r;
    int xfer_before;
    int ms_before;

    vecs[0] = '{OP_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0};
    vecs[1] = '{OP_SUB, 32'd7,         32'd5,         32'd2,         1'b1};
    vecs[2] = '{OP_SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{OP_LT,  32'd3,         32'd9,         32'd1,         1'b0};
    vecs[4] = '{OP_NOR, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.mod_done  = 1'b0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("por");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while waiting on the modulo unit: nothing may come out.
    bus.rsp_ready = 1'b1;
    send(OP_MOD, 32'd17, 32'd5, e);
    @(negedge clk);
    check("mwait_mod_start", bus.mod_start, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", bus.rsp_valid, 0);
      check("post_rst_req_ready", bus.req_ready, 1);
    end

    // Add with carry-out: 0xFFFFFFFF + 1.
    expect_rsp(32'h0, 1'b1, 1'b0);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, e);
    @(negedge clk);
    check("add_alu_sel",   bus.alu_sel,   OP_ADD);
    check("add_alu_a",     bus.alu_a,     32'hFFFF_FFFF);
    check("add_alu_b",     bus.alu_b,     32'h1);
    check("add_req_ready", bus.req_ready, 0);
    wait_rsp(r);
    check("add_latency", r, e + 2);
    @(negedge clk);
    check("add_req_ready_after", bus.req_ready, 1);
    check("add_rsp_valid_after", bus.rsp_valid, 0);

    // AND under 5 cycles of backpressure, then a single transfer.
    bus.rsp_ready = 1'b0;
    expect_rsp(32'h00F0_00F0, 1'b0, 1'b0);
    send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, e);
    wait_rsp(r);
    check("and_latency", r, e + 2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("and_hold_data",      bus.rsp_data,  32'h00F0_00F0);
      check("and_hold_req_ready", bus.req_ready, 0);
      check("and_hold_valid",     bus.rsp_valid, 1);
    end
    xfer_before = n_xfer;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("and_valid_dropped", bus.rsp_valid, 0);
    check("and_single_xfer",   n_xfer, xfer_before + 1);

    // Remaining logic/arith ops.
    foreach (vecs[i]) begin
      expect_rsp(vecs[i].data, vecs[i].cout, 1'b0);
      send(vecs[i].op, vecs[i].a, vecs[i].b, e);
      wait_rsp(r);
      check("op_latency", r, e + 2);
    end

    // Modulo 17 % 5: done sampled 4 edges after acceptance.
    @(negedge clk);
    n_mod_start = 0;
    expect_rsp(32'd2, 1'b0, 1'b0);
    send(OP_MOD, 32'd17, 32'd5, e);
    repeat (3) @(posedge clk);
    #1 bus.mod_done = 1'b1;
    @(posedge clk);
    #1 bus.mod_done = 1'b0;
    wait_rsp(r);
    check("mod_latency", r, e + 5);
    repeat (2) @(negedge clk);
    check("mod_start_pulses", n_mod_start, 1);

    // Modulo by zero: immediate error, no start pulse.
    ms_before = n_mod_start;
    expect_rsp(32'd0, 1'b0, 1'b1);
    send(OP_MOD, 32'd9, 32'd0, e);
    wait_rsp(r);
    check("modzero_latency", r, e + 1);
    repeat (2) @(negedge clk);
    check("modzero_no_start", n_mod_start, ms_before);

    // Timeout: mod_done never arrives, error after 64 waiting cycles.
    expect_rsp(32'd0, 1'b0, 1'b1);
    send(OP_MOD, 32'd20, 32'd3, e);
    wait_rsp(r);
    check("timeout_latency", r, e + TO + 1);

    // mod_done on the 64th waiting cycle beats the timeout.
    expect_rsp(32'd2, 1'b0, 1'b0);
    send(OP_MOD, 32'd20, 32'd3, e);
    repeat (TO - 1) @(posedge clk);
    #1 bus.mod_done = 1'b1;
    @(posedge clk);
    #1 bus.mod_done = 1'b0;
    wait_rsp(r);
    check("late_done_latency", r, e + TO + 1);

    // Stray mod_done while idle must not produce a response.
    repeat (2) @(posedge clk);
    #1 bus.mod_done = 1'b1;
    @(posedge clk);
    #1 bus.mod_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stray_done_no_rsp", bus.rsp_valid, 0);
    end

    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
